axi_master_read_port: RTL and testbench
=======================================

Name: axi_master_read_port

Overview:
- CPU-side AXI read master that sits directly upstream of the SRAM AXI slave wrapper, through the interconnect.
- Converts a simple CPU fetch/load request (req, addr, len) into one AXI AR handshake followed by an R-channel burst.
- Returns each data beat to the CPU with a valid pulse and holds the CPU stalled until the burst completes.
- One outstanding transaction only.

Parameters:
- MASTER_ID, 4'd0, value driven on ARID; only R beats whose RID equals it are accepted.
- MAX_LEN, 4'd15, largest ARLEN accepted; cpu_len above this is clamped to MAX_LEN.

Ports:
- ACLK  input  1  clock
- ARESETn  input  1  asynchronous active-low reset
- cpu_req  input  1  read request, sampled only in IDLE
- cpu_addr  input  32  byte address, latched on accept
- cpu_len  input  4  beats minus one, latched on accept
- cpu_stall  output  1  high from the accept cycle through the cycle of the last beat
- cpu_rdata  output  32  registered beat data
- cpu_rvalid  output  1  one-cycle pulse per forwarded beat
- cpu_done  output  1  one-cycle pulse after the last beat
- ARID  output  4  = MASTER_ID
- ARADDR  output  32  latched address
- ARLEN  output  4  latched length
- ARSIZE  output  3  fixed 3'b010
- ARBURST  output  2  fixed 2'b01 (INCR)
- ARVALID  output  1  address valid
- ARREADY  input  1  address ready
- RID  input  4  read ID
- RDATA  input  32  read data
- RRESP  input  2  read response
- RLAST  input  1  last beat
- RVALID  input  1  data valid
- RREADY  output  1  data ready

Behaviour:
- Reset (async, ARESETn=0): state=IDLE. ARVALID, RREADY, cpu_stall, cpu_rvalid and cpu_done are 0. ARADDR, ARLEN, cpu_rdata and the beat counter are 0. Takes effect immediately, including mid-burst. After reset the block never completes the aborted burst.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - cpu_req=1 → latch addr and len (clamped), go to ADDR.
  - cpu_stall is combinationally high in the accept cycle.
- ADDR:
  - ARVALID=1; ARADDR and ARLEN stay stable until ARREADY.
  - ARVALID&ARREADY → DATA next cycle.
  - ARVALID is never dropped before the handshake.
- DATA:
  - RREADY=1.
  - A beat is RVALID&RREADY&(RID==MASTER_ID). Beats with a mismatched RID are consumed but not forwarded or counted.
  - Each accepted beat: cpu_rdata<=RDATA, cpu_rvalid pulses the next cycle, beat counter increments (4-bit, wraps at 16, never exceeds ARLEN+1 in legal traffic).
  - Accepted beat with RLAST=1 → DONE. Completion is by RLAST only, not by the count.
- DONE:
  - cpu_done=1 for one cycle, cpu_stall=0, counter cleared, → IDLE.
  - A new request can be accepted the cycle after DONE, so back-to-back bursts have a 1-cycle bubble.
- Latency: single beat with ARREADY and RVALID each returned in the next cycle:
  - accept at T0;
  - ARVALID at T1, handshake at T1;
  - RREADY at T2, beat at T2;
  - cpu_rvalid and cpu_done at T3.
- cpu_req while busy is ignored; the CPU holds it under cpu_stall.
- Address increment is the slave's job; ARADDR is not modified during the burst.

Optional Feature:
- Macro: AXI_MASTER_READ_ERR_EN.
- When defined, adds outputs err_flag (1) and err_code (2).
  - err_flag is sticky; it sets on an accepted beat with RRESP!=2'b00 (err_code=RRESP), or when RLAST arrives with beat count != ARLEN+1 (err_code=2'b11).
  - Only the first error is recorded.
  - Cleared by reset or by the next accepted cpu_req.
- When undefined, these ports do not exist, RRESP is ignored, and there is no error logic.

Test Plan:
- Single read: cpu_addr=32'h0000_0010, cpu_len=0; slave returns 32'hDEADBEEF with RLAST → ARLEN=0, ARSIZE=2, ARBURST=1, cpu_rvalid once with DEADBEEF, cpu_done at T3, cpu_stall low after.
- Burst of 4: cpu_len=3; RDATA 1,2,3,4 with RLAST on 4 and RVALID gaps of 2 cycles → four cpu_rvalid pulses in order, cpu_done once, RREADY high throughout DATA.
- ARREADY delayed 5 cycles → ARVALID, ARADDR and ARLEN stable for all 6 cycles; no RREADY before the handshake.
- Foreign beat RID=4'd1 (MASTER_ID=0) with data 32'h55 before the real beat 32'hAA → only AA forwarded; the counter counts 1.
- ARESETn low in the middle of the 2nd beat of a 4-beat burst → outputs zero immediately; after release, a new cpu_req at addr 32'h20 completes normally.
- With AXI_MASTER_READ_ERR_EN: RRESP=2'b10 on beat 2 → err_flag=1, err_code=2'b10, held until the next cpu_req; early RLAST on beat 2 of len=3 on a clean run → err_code=2'b11.

Source files
------------

// File: rtl/axi_master_read_port_if.sv
// AXI read-address and read-data channel bundle between a CPU-side read
// master and the interconnect / SRAM slave wrapper.
interface axi_master_read_port_if;

  // Read address channel
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;

  // Read data channel
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output ARID,
    output ARADDR,
    output ARLEN,
    output ARSIZE,
    output ARBURST,
    output ARVALID,
    input  ARREADY,
    input  RID,
    input  RDATA,
    input  RRESP,
    input  RLAST,
    input  RVALID,
    output RREADY
  );

  modport slave (
    input  ARID,
    input  ARADDR,
    input  ARLEN,
    input  ARSIZE,
    input  ARBURST,
    input  ARVALID,
    output ARREADY,
    output RID,
    output RDATA,
    output RRESP,
    output RLAST,
    output RVALID,
    input  RREADY
  );

endinterface

// File: rtl/axi_master_read_port.sv
// CPU-side AXI read master: turns one CPU request (addr, len) into a single AR
// handshake followed by an INCR R-channel burst, forwarding each beat to the CPU.
// One transaction outstanding; the CPU is stalled until the burst's last beat.
//
// Optional build macro AXI_MASTER_READ_ERR_EN adds sticky err_flag / err_code
// outputs recording the first bad response or RLAST/length disagreement.
module axi_master_read_port #(
  parameter logic [3:0] MASTER_ID = 4'd0,
  parameter logic [3:0] MAX_LEN   = 4'd15
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic                   cpu_req,
  input  logic [31:0]            cpu_addr,
  input  logic [3:0]             cpu_len,
  output logic                   cpu_stall,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_rvalid,
  output logic                   cpu_done,
`ifdef AXI_MASTER_READ_ERR_EN
  output logic                   err_flag,
  output logic [1:0]             err_code,
`endif
  axi_master_read_port_if.master axi
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StData = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [2:0] ArSizeWord = 3'b010;
  localparam logic [1:0] ArBurstIncr = 2'b01;

  logic [1:0]  state_q, state_d;
  logic [31:0] araddr_q;
  logic [3:0]  arlen_q;
  logic [3:0]  len_clamped;
  logic [31:0] rdata_q;
  logic        rvalid_q;
  logic [3:0]  beat_cnt_q;
  logic        accept;
  logic        beat_ok;

  // A request is only looked at while idle; busy-time requests are ignored.
  assign accept = (state_q == StIdle) && cpu_req;

  // Beats tagged for another master are drained (RREADY is high) but dropped.
  assign beat_ok = (state_q == StData) && axi.RVALID && (axi.RID == MASTER_ID);

  assign len_clamped = (cpu_len > MAX_LEN) ? MAX_LEN : cpu_len;

  // Next-state selection; completion is signalled by RLAST alone.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (cpu_req) state_d = StAddr;
      StAddr:  if (axi.ARREADY) state_d = StData;
      StData:  if (beat_ok && axi.RLAST) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register; reset abandons any burst in flight.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch address and clamped length on accept; held through the burst.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      araddr_q <= 32'h0;
      arlen_q  <= 4'h0;
    end else if (accept) begin
      araddr_q <= cpu_addr;
      arlen_q  <= len_clamped;
    end
  end

  // Register each accepted beat toward the CPU with a one-cycle valid pulse.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= beat_ok;
      if (beat_ok) begin
        rdata_q <= axi.RDATA;
      end
    end
  end

  // Count accepted beats of the current burst; wraps naturally at 16.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      beat_cnt_q <= 4'h0;
    end else if (state_q == StDone) begin
      beat_cnt_q <= 4'h0;
    end else if (beat_ok) begin
      beat_cnt_q <= beat_cnt_q + 4'd1;
    end
  end

`ifdef AXI_MASTER_READ_ERR_EN
  logic       err_flag_q;
  logic [1:0] err_code_q;

  // Sticky first-error capture; a new accepted request starts clean.
  // A bad RRESP takes priority over a length mismatch on the same beat.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      err_flag_q <= 1'b0;
      err_code_q <= 2'b00;
    end else if (accept) begin
      err_flag_q <= 1'b0;
      err_code_q <= 2'b00;
    end else if (beat_ok && !err_flag_q) begin
      if (axi.RRESP != 2'b00) begin
        err_flag_q <= 1'b1;
        err_code_q <= axi.RRESP;
      end else if (axi.RLAST && (beat_cnt_q != arlen_q)) begin
        // beat_cnt_q holds beats before this one, so equality means ARLEN+1 total
        err_flag_q <= 1'b1;
        err_code_q <= 2'b11;
      end
    end
  end

  assign err_flag = err_flag_q;
  assign err_code = err_code_q;
`endif

  // Legal slaves never return more than ARLEN+1 beats for our ID.
  property p_beat_count_in_range;
    @(posedge ACLK) disable iff (!ARESETn) beat_ok |-> (beat_cnt_q <= arlen_q);
  endproperty
  assert property (p_beat_count_in_range);

  // AXI address channel outputs
  assign axi.ARID    = MASTER_ID;
  assign axi.ARADDR  = araddr_q;
  assign axi.ARLEN   = arlen_q;
  assign axi.ARSIZE  = ArSizeWord;
  assign axi.ARBURST = ArBurstIncr;
  assign axi.ARVALID = (state_q == StAddr);
  assign axi.RREADY  = (state_q == StData);

  // CPU-side outputs; stall covers the accept cycle combinationally.
  assign cpu_stall  = (accept && ARESETn) || (state_q == StAddr) || (state_q == StData);
  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = rvalid_q;
  assign cpu_done   = (state_q == StDone);

endmodule

// File: tb/tb_axi_master_read_port.sv
// Self-checking bench for axi_master_read_port: directed scenarios plus
// randomized bursts checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_axi_master_read_port;

  localparam logic [3:0] MID = 4'd0;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [3:0]  cpu_len = 4'h0;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_done;
`ifdef AXI_MASTER_READ_ERR_EN
  logic        err_flag;
  logic [1:0]  err_code;
`endif

  axi_master_read_port_if axi ();

  axi_master_read_port #(
    .MASTER_ID(MID),
    .MAX_LEN  (4'd15)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_len   (cpu_len),
    .cpu_stall (cpu_stall),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .cpu_done  (cpu_done),
`ifdef AXI_MASTER_READ_ERR_EN
    .err_flag  (err_flag),
    .err_code  (err_code),
`endif
    .axi       (axi.master)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int txn_cycles;
  int done_cnt;
  int gap;
  int ar_delay;
  logic [31:0] got_q[$];
  logic [31:0] b_data[$];
  logic [3:0]  b_id[$];
  logic        b_last[$];
  logic [1:0]  b_resp[$];

  always @(posedge ACLK) cyc++;

  // Collect what the CPU side sees.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (cpu_rvalid === 1'b1) got_q.push_back(cpu_rdata);
      if (cpu_done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_beats();
    b_data.delete();
    b_id.delete();
    b_last.delete();
    b_resp.delete();
  endtask

  task automatic add_beat(input logic [31:0] d, input logic [3:0] id, input logic last,
                          input logic [1:0] resp);
    b_data.push_back(d);
    b_id.push_back(id);
    b_last.push_back(last);
    b_resp.push_back(resp);
  endtask

  // Issue one request and play the slave side; returns at the negedge where
  // cpu_done is visible (or after the wait bound expires).
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] len);
    int t;
    int start;
    logic [47:0] got_v;
    logic [47:0] exp_v;
    got_q.delete();
    done_cnt = 0;
    start = cyc;
    cpu_req = 1'b1;
    cpu_addr = addr;
    cpu_len = len;
    #1;
    checks++;
    if (cpu_stall !== 1'b1) $display("FAIL stall_on_accept got=%b exp=1", cpu_stall);
    else passed++;
    @(negedge ACLK);
    cpu_req = 1'b0;
    cpu_addr = $urandom;
    cpu_len = 4'($urandom);
    for (int c = 0; c <= ar_delay; c++) begin
      got_v = {axi.ARVALID, axi.ARADDR, axi.ARLEN, axi.ARID, axi.ARSIZE, axi.ARBURST,
               axi.RREADY, cpu_stall};
      exp_v = {1'b1, addr, len, MID, 3'b010, 2'b01, 1'b0, 1'b1};
      checks++;
      if (got_v !== exp_v) $display("FAIL addr_phase c=%0d got=%h exp=%h", c, got_v, exp_v);
      else passed++;
`ifdef AXI_MASTER_READ_ERR_EN
      if (c == 0) begin
        checks++;
        if (err_flag !== 1'b0) $display("FAIL err_clear_on_accept got=%b exp=0", err_flag);
        else passed++;
      end
`endif
      if (c == ar_delay) axi.ARREADY = 1'b1;
      @(negedge ACLK);
    end
    axi.ARREADY = 1'b0;
    for (int i = 0; i < b_data.size(); i++) begin
      axi.RVALID = 1'b0;
      for (int g = 0; g < gap; g++) begin
        checks++;
        if ({axi.RREADY, cpu_stall} !== 2'b11)
          $display("FAIL rready_gap beat=%0d got=%b exp=11", i, {axi.RREADY, cpu_stall});
        else passed++;
        @(negedge ACLK);
      end
      checks++;
      if (axi.RREADY !== 1'b1) $display("FAIL rready_beat beat=%0d got=%b exp=1", i, axi.RREADY);
      else passed++;
      axi.RVALID = 1'b1;
      axi.RDATA = b_data[i];
      axi.RID = b_id[i];
      axi.RLAST = b_last[i];
      axi.RRESP = b_resp[i];
      @(negedge ACLK);
    end
    axi.RVALID = 1'b0;
    axi.RLAST = 1'b0;
    t = 0;
    while (cpu_done !== 1'b1 && t < 8) begin
      @(negedge ACLK);
      t++;
    end
    txn_cycles = cyc - start;
    checks++;
    if (cpu_done !== 1'b1) $display("FAIL done_timeout got=%b exp=1", cpu_done);
    else passed++;
  endtask

  // Compare collected beats to the model; call once time has moved past done.
  task automatic check_txn(input string name);
    logic [31:0] exp_q[$];
    logic seen_last;
    int bad;
    seen_last = 1'b0;
    for (int i = 0; i < b_data.size(); i++) begin
      if (!seen_last && b_id[i] == MID) begin
        exp_q.push_back(b_data[i]);
        if (b_last[i]) seen_last = 1'b1;
      end
    end
    checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL %s beat_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
    else passed++;
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    checks++;
    if (bad >= 0) $display("FAIL %s data idx=%0d got=%h exp=%h", name, bad, got_q[bad], exp_q[bad]);
    else passed++;
    checks++;
    if (done_cnt != 1) $display("FAIL %s done_pulses got=%0d exp=1", name, done_cnt);
    else passed++;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    cpu_req = 1'b1;
    #13;
    checks++;
    if ({axi.ARVALID, axi.RREADY, cpu_stall, cpu_rvalid, cpu_done} !== 5'b0)
      $display("FAIL reset_ctrl got=%b exp=00000",
               {axi.ARVALID, axi.RREADY, cpu_stall, cpu_rvalid, cpu_done});
    else passed++;
    checks++;
    if ({cpu_rdata, axi.ARADDR, axi.ARLEN} !== 68'h0)
      $display("FAIL reset_data got=%h exp=0", {cpu_rdata, axi.ARADDR, axi.ARLEN});
    else passed++;
    cpu_req = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
  endtask

  task automatic test_single();
    clear_beats();
    add_beat(32'hDEADBEEF, MID, 1'b1, 2'b00);
    gap = 0;
    ar_delay = 0;
    run_txn(32'h0000_0010, 4'd0);
    checks++;
    if (txn_cycles != 3) $display("FAIL single_latency got=%0d exp=3", txn_cycles);
    else passed++;
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'hDEADBEEF})
      $display("FAIL single_t3 got=%h exp=%h", {cpu_rvalid, cpu_rdata}, {1'b1, 32'hDEADBEEF});
    else passed++;
    @(negedge ACLK);
    #1;
    check_txn("single");
    checks++;
    if ({cpu_stall, cpu_rvalid, cpu_done} !== 3'b000)
      $display("FAIL single_after got=%b exp=000", {cpu_stall, cpu_rvalid, cpu_done});
    else passed++;
  endtask

  task automatic test_burst4();
    clear_beats();
    for (int i = 1; i <= 4; i++) add_beat(32'(i), MID, (i == 4), 2'b00);
    gap = 2;
    ar_delay = 0;
    run_txn(32'h0000_0100, 4'd3);
    @(negedge ACLK);
    #1;
    check_txn("burst4");
  endtask

  task automatic test_ar_delay();
    clear_beats();
    for (int i = 0; i < 3; i++) add_beat($urandom, MID, (i == 2), 2'b00);
    gap = 0;
    ar_delay = 5;
    run_txn(32'h1234_5670, 4'd2);
    @(negedge ACLK);
    #1;
    check_txn("ar_delay");
  endtask

  task automatic test_foreign();
    clear_beats();
    add_beat(32'h55, 4'd1, 1'b0, 2'b00);
    add_beat(32'hAA, MID, 1'b1, 2'b00);
    gap = 0;
    ar_delay = 1;
    run_txn(32'h0000_0200, 4'd0);
    @(negedge ACLK);
    #1;
    check_txn("foreign");
`ifdef AXI_MASTER_READ_ERR_EN
    checks++;
    if (err_flag !== 1'b0) $display("FAIL foreign_count got_err=%b exp=0", err_flag);
    else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    clear_beats();
    add_beat(32'hA0A0_0001, MID, 1'b0, 2'b00);
    add_beat(32'hA0A0_0002, MID, 1'b1, 2'b00);
    gap = 0;
    ar_delay = 0;
    run_txn(32'h0000_0300, 4'd1);
    cpu_req = 1'b1;
    cpu_addr = 32'h0000_0400;
    cpu_len = 4'd1;
    #1;
    checks++;
    if (cpu_stall !== 1'b0) $display("FAIL b2b_done_stall got=%b exp=0", cpu_stall);
    else passed++;
    @(negedge ACLK);
    #1;
    check_txn("b2b_first");
    checks++;
    if ({cpu_stall, axi.ARVALID} !== 2'b10)
      $display("FAIL b2b_bubble got=%b exp=10", {cpu_stall, axi.ARVALID});
    else passed++;
    clear_beats();
    add_beat(32'hB0B0_0001, MID, 1'b0, 2'b00);
    add_beat(32'hB0B0_0002, MID, 1'b1, 2'b00);
    run_txn(32'h0000_0400, 4'd1);
    @(negedge ACLK);
    #1;
    check_txn("b2b_second");
  endtask

  task automatic test_random();
    logic [3:0] len;
    for (int n = 0; n < 20; n++) begin
      clear_beats();
      len = 4'($urandom_range(0, 15));
      for (int k = 0; k <= int'(len); k++) begin
        if ($urandom_range(0, 3) == 0)
          add_beat($urandom, 4'($urandom_range(1, 15)), 1'($urandom), 2'b00);
        add_beat($urandom, MID, (k == int'(len)), 2'b00);
      end
      gap = $urandom_range(0, 2);
      ar_delay = $urandom_range(0, 3);
      @(negedge ACLK);
      run_txn({$urandom, 2'b00} & 32'hFFFF_FFFC, len);
      @(negedge ACLK);
      #1;
      check_txn("random");
    end
  endtask

  task automatic test_async_reset();
    @(negedge ACLK);
    cpu_req = 1'b1;
    cpu_addr = 32'h0000_0040;
    cpu_len = 4'd3;
    @(negedge ACLK);
    cpu_req = 1'b0;
    axi.ARREADY = 1'b1;
    @(negedge ACLK);
    axi.ARREADY = 1'b0;
    axi.RVALID = 1'b1;
    axi.RID = MID;
    axi.RDATA = 32'h11;
    axi.RLAST = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'h11})
      $display("FAIL arst_beat1 got=%h exp=%h", {cpu_rvalid, cpu_rdata}, {1'b1, 32'h11});
    else passed++;
    axi.RDATA = 32'h22;
    #2;
    ARESETn = 1'b0;
    #1;
    checks++;
    if ({axi.ARVALID, axi.RREADY, cpu_stall, cpu_rvalid, cpu_done} !== 5'b0)
      $display("FAIL arst_ctrl got=%b exp=00000",
               {axi.ARVALID, axi.RREADY, cpu_stall, cpu_rvalid, cpu_done});
    else passed++;
    checks++;
    if ({cpu_rdata, axi.ARADDR, axi.ARLEN} !== 68'h0)
      $display("FAIL arst_data got=%h exp=0", {cpu_rdata, axi.ARADDR, axi.ARLEN});
    else passed++;
    axi.RDATA = 32'h99;
    axi.RLAST = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    got_q.delete();
    done_cnt = 0;
    repeat (3) @(negedge ACLK);
    #1;
    checks++;
    if (got_q.size() != 0 || done_cnt != 0 || axi.RREADY !== 1'b0)
      $display("FAIL arst_abandon got_beats=%0d got_done=%0d rready=%b exp=0/0/0",
               got_q.size(), done_cnt, axi.RREADY);
    else passed++;
    axi.RVALID = 1'b0;
    axi.RLAST = 1'b0;
    clear_beats();
    add_beat(32'hC001_0001, MID, 1'b0, 2'b00);
    add_beat(32'hC001_0002, MID, 1'b1, 2'b00);
    gap = 1;
    ar_delay = 0;
    @(negedge ACLK);
    run_txn(32'h0000_0020, 4'd1);
    @(negedge ACLK);
    #1;
    check_txn("after_reset");
  endtask

`ifdef AXI_MASTER_READ_ERR_EN
  task automatic test_err();
    clear_beats();
    add_beat(32'h1, MID, 1'b0, 2'b00);
    add_beat(32'h2, MID, 1'b0, 2'b10);
    add_beat(32'h3, MID, 1'b0, 2'b01);
    add_beat(32'h4, MID, 1'b1, 2'b00);
    gap = 0;
    ar_delay = 0;
    @(negedge ACLK);
    run_txn(32'h0000_0500, 4'd3);
    repeat (3) @(negedge ACLK);
    #1;
    checks++;
    if ({err_flag, err_code} !== 3'b110)
      $display("FAIL err_slverr got=%b exp=110", {err_flag, err_code});
    else passed++;
    clear_beats();
    add_beat(32'h5, MID, 1'b0, 2'b00);
    add_beat(32'h6, MID, 1'b1, 2'b00);
    run_txn(32'h0000_0600, 4'd3);
    @(negedge ACLK);
    #1;
    checks++;
    if ({err_flag, err_code} !== 3'b111)
      $display("FAIL err_early_last got=%b exp=111", {err_flag, err_code});
    else passed++;
  endtask
`endif

  initial begin
    axi.ARREADY = 1'b0;
    axi.RVALID = 1'b0;
    axi.RID = 4'h0;
    axi.RDATA = 32'h0;
    axi.RRESP = 2'b00;
    axi.RLAST = 1'b0;
    done_cnt = 0;
    test_reset();
    test_single();
    test_burst4();
    test_ar_delay();
    test_foreign();
    test_back_to_back();
    test_random();
    test_async_reset();
`ifdef AXI_MASTER_READ_ERR_EN
    test_err();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
